// File: rtl/output_port_arbiter.sv
// -----------------------------------------------------------------------------
// output_port_arbiter
//
// One instance sits on each router output port. The five per-input routing
// units each raise a request bit toward this port. The arbiter grants one
// request per cycle in round-robin order, captures the winning flit into a
// small FIFO buffer, and drains that buffer into the downstream input FIFO
// while the downstream FIFO is not full.
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous reset, active-high
//   req       req[i] is input i's request for this output port
//   data_in   flit of input i on bits [i*WIDTH +: WIDTH]
//   grant     one-hot grant to the winning input, valid in the same cycle
//   data_out  head-of-buffer flit
//   wr_en     write strobe into the downstream FIFO
//   dst_full  downstream FIFO full
//   count     buffer occupancy, for debug
//
// Handshakes
//   Upstream: req is a level request. A flit transfers at the clock edge
//   where grant[i]=1. An input that gets no grant keeps req high and tries
//   again later without losing its place in the rotation.
//   Downstream: wr_en acts as valid and !dst_full acts as ready. wr_en is
//   already gated by dst_full, so every cycle with wr_en=1 is a completed
//   write of data_out.
// -----------------------------------------------------------------------------
module output_port_arbiter #(
  parameter int WIDTH = 12,
  parameter int NPORT = 5,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NPORT-1:0]           req,
  input  logic [NPORT*WIDTH-1:0]     data_in,
  output logic [NPORT-1:0]           grant,
  output logic [WIDTH-1:0]           data_out,
  output logic                       wr_en,
  input  logic                       dst_full,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  // Round-robin pointer: the input that is scanned first.
  logic [PW-1:0]    ptr;
  // Buffer storage and its indices.
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    rd_idx;
  logic [CW-1:0]    count_q;

  logic             space;
  logic             push;
  logic             pop;
  logic             found;
  logic [PW-1:0]    win_idx;
  logic [NPORT-1:0] grant_c;

  // Space is based on the registered count only. A pop in the same cycle
  // does not free a slot, which keeps dst_full off the grant path.
  assign space = (count_q < CW'(DEPTH));

  // Round-robin scan starting at ptr and wrapping modulo NPORT.
  always_comb begin : rr_scan
    int idx;
    grant_c = '0;
    win_idx = '0;
    found   = 1'b0;
    idx     = 0;
    if (space) begin
      for (int k = 0; k < NPORT; k++) begin
        idx = int'(ptr) + k;
        if (idx >= NPORT) idx = idx - NPORT;
        if (!found && req[idx]) begin
          found        = 1'b1;
          win_idx      = PW'(idx);
          grant_c[idx] = 1'b1;
        end
      end
    end
  end

  assign grant    = grant_c;
  assign push     = found;
  assign pop      = (count_q != '0) && !dst_full;
  assign wr_en    = pop;
  assign data_out = mem[rd_idx];
  assign count    = count_q;

  // Pointer, indices and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr     <= '0;
      wr_idx  <= '0;
      rd_idx  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        // The input after the winner gets first look next time.
        ptr    <= (win_idx == PW'(NPORT - 1)) ? '0 : win_idx + PW'(1);
        wr_idx <= (wr_idx == AW'(DEPTH - 1)) ? '0 : wr_idx + AW'(1);
      end
      if (pop) begin
        rd_idx <= (rd_idx == AW'(DEPTH - 1)) ? '0 : rd_idx + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Flit storage is not reset. Its contents do not matter while the
  // matching count is zero.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_idx] <= data_in[int'(win_idx)*WIDTH +: WIDTH];
    end
  end

endmodule

// File: tb/tb_output_port_arbiter.sv
module tb_output_port_arbiter;

  localparam int WIDTH = 12;
  localparam int NPORT = 5;
  localparam int DEPTH = 2;

  // ---------------- clock / reset ----------------
  logic                   clk = 1'b0;
  logic                   rst;
  logic [NPORT-1:0]       req;
  logic [NPORT*WIDTH-1:0] data_in;
  logic [NPORT-1:0]       grant;
  logic [WIDTH-1:0]       data_out;
  logic                   wr_en;
  logic                   dst_full;
  logic [1:0]             count;

  always #5 clk = ~clk;

  output_port_arbiter #(.WIDTH(WIDTH), .NPORT(NPORT), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .data_in  (data_in),
    .grant    (grant),
    .data_out (data_out),
    .wr_en    (wr_en),
    .dst_full (dst_full),
    .count    (count)
  );

  // ---------------- scoreboard ----------------
  logic [WIDTH-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [NPORT*WIDTH-1:0] rand_data();
    logic [NPORT*WIDTH-1:0] d;
    for (int i = 0; i < NPORT; i++) d[i*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 4095));
    return d;
  endfunction

  // ---------------- driver ----------------
  // One clock cycle: drive at the falling edge, sample 1 ns later, then
  // let the rising edge commit. Reset cycles are not checked; they flush
  // the expected queue.
  task automatic step(input logic r, input logic [NPORT-1:0] rq, input logic df,
                      input logic [NPORT*WIDTH-1:0] din, input logic [NPORT-1:0] eg,
                      input logic ew, input logic [1:0] ec, input string tag);
    logic [WIDTH-1:0] exp_flit;
    @(negedge clk);
    rst = r; req = rq; dst_full = df; data_in = din;
    #1;
    if (!r) begin
      check({tag, " grant"}, 32'(grant), 32'(eg));
      check({tag, " wr_en"}, 32'(wr_en), 32'(ew));
      check({tag, " count"}, 32'(count), 32'(ec));
      if (wr_en) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL %s data_out: write of %0h with no flit expected", tag, data_out);
        end else begin
          exp_flit = exp_q.pop_front();
          check({tag, " data_out"}, 32'(data_out), 32'(exp_flit));
        end
      end
      for (int i = 0; i < NPORT; i++)
        if (eg[i]) exp_q.push_back(din[i*WIDTH +: WIDTH]);
    end
    @(posedge clk);
    if (r) exp_q.delete();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic             rst;
    logic [NPORT-1:0] req;
    logic             dst_full;
    logic             pin2;       // force input 2's flit to 12'hA5C
    logic [NPORT-1:0] exp_grant;
    logic             exp_wr;
    logic [1:0]       exp_count;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic [NPORT-1:0] rq, input logic df,
                              input logic p2, input logic [NPORT-1:0] eg,
                              input logic ew, input logic [1:0] ec);
    vec_t v;
    v.rst = r; v.req = rq; v.dst_full = df; v.pin2 = p2;
    v.exp_grant = eg; v.exp_wr = ew; v.exp_count = ec;
    return v;
  endfunction

  initial begin
    logic [NPORT*WIDTH-1:0] d;
    rst = 1'b1; req = '0; dst_full = 1'b0; data_in = '0;

    // Reset, idle, single grant on input 2, latency, pointer after grant.
    tbl.push_back(mk(1'b1, 5'b00000, 1'b0, 1'b0, 5'b00000, 1'b0, 2'd0));
    tbl.push_back(mk(1'b0, 5'b00000, 1'b0, 1'b0, 5'b00000, 1'b0, 2'd0));
    tbl.push_back(mk(1'b0, 5'b00100, 1'b0, 1'b1, 5'b00100, 1'b0, 2'd0));
    tbl.push_back(mk(1'b0, 5'b00000, 1'b0, 1'b0, 5'b00000, 1'b1, 2'd1));
    // ptr=3: input 4 wins over input 0 and input 2.
    tbl.push_back(mk(1'b0, 5'b10101, 1'b0, 1'b0, 5'b10000, 1'b0, 2'd0));
    tbl.push_back(mk(1'b0, 5'b00000, 1'b0, 1'b0, 5'b00000, 1'b1, 2'd1));
    // All inputs requesting for 10 cycles from ptr=0.
    for (int k = 0; k < 10; k++)
      tbl.push_back(mk(1'b0, 5'b11111, 1'b0, 1'b0, 5'(1 << (k % 5)), (k != 0), (k != 0) ? 2'd1 : 2'd0));
    tbl.push_back(mk(1'b0, 5'b00000, 1'b0, 1'b0, 5'b00000, 1'b1, 2'd1));

    foreach (tbl[i]) begin
      d = rand_data();
      if (tbl[i].pin2) d[2*WIDTH +: WIDTH] = 12'hA5C;
      step(tbl[i].rst, tbl[i].req, tbl[i].dst_full, d,
           tbl[i].exp_grant, tbl[i].exp_wr, tbl[i].exp_count, $sformatf("tbl%0d", i));
    end

    // Backpressure fills the buffer; grants stop at DEPTH; drain is in order.
    // A drain in the same cycle does not reopen space. ptr starts at 0.
    step(0, 5'b00011, 1, rand_data(), 5'b00001, 0, 2'd0, "bp0");
    step(0, 5'b00011, 1, rand_data(), 5'b00010, 0, 2'd1, "bp1");
    step(0, 5'b00011, 1, rand_data(), 5'b00000, 0, 2'd2, "bp_full");
    step(0, 5'b00011, 1, rand_data(), 5'b00000, 0, 2'd2, "bp_hold");
    step(0, 5'b00011, 0, rand_data(), 5'b00000, 1, 2'd2, "bp_drain0");
    step(0, 5'b00000, 0, rand_data(), 5'b00000, 1, 2'd1, "bp_drain1");

    // Pointer wrap: ptr=2 -> grant input 3 -> ptr=4 -> input 4 -> wrap to 0.
    step(0, 5'b01000, 0, rand_data(), 5'b01000, 0, 2'd0, "wrap_set");
    step(0, 5'b10001, 0, rand_data(), 5'b10000, 1, 2'd1, "wrap_4");
    step(0, 5'b10001, 0, rand_data(), 5'b00001, 1, 2'd1, "wrap_0");
    step(0, 5'b00000, 0, rand_data(), 5'b00000, 1, 2'd1, "wrap_drain");

    // Simultaneous push and pop at count=1 (ptr=1 on entry).
    step(0, 5'b00001, 0, rand_data(), 5'b00001, 0, 2'd0, "pp_fill");
    step(0, 5'b01000, 0, rand_data(), 5'b01000, 1, 2'd1, "pp_a");
    step(0, 5'b01000, 0, rand_data(), 5'b01000, 1, 2'd1, "pp_b");
    step(0, 5'b00000, 0, rand_data(), 5'b00000, 1, 2'd1, "pp_drain");

    // Reset with a full buffer and a pending request (ptr=4 on entry).
    step(0, 5'b00110, 1, rand_data(), 5'b00010, 0, 2'd0, "rst_fill0");
    step(0, 5'b00110, 1, rand_data(), 5'b00100, 0, 2'd1, "rst_fill1");
    step(0, 5'b00110, 1, rand_data(), 5'b00000, 0, 2'd2, "rst_full");
    step(1, 5'b00110, 1, rand_data(), 5'b00000, 0, 2'd0, "rst_pulse");
    step(0, 5'b00110, 0, rand_data(), 5'b00010, 0, 2'd0, "rst_after");
    step(0, 5'b00000, 0, rand_data(), 5'b00000, 1, 2'd1, "rst_drain");
    step(0, 5'b00000, 0, rand_data(), 5'b00000, 0, 2'd0, "rst_empty");

    check("leftover_flits", 32'(exp_q.size()), 32'd0);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/output_port_arbiter.md
Name: output_port_arbiter

Overview:
- One instance per router output port (processor, east, south, west, north).
- Collects the one-hot requests that the five per-input routing units raise for this output, and picks one input per cycle by round-robin.
- Returns the grant to the winning input in the same cycle and captures that input's 12-bit flit into a small output buffer.
- Drains the buffer into the downstream input FIFO (neighbour router or local processor), honouring that FIFO's full flag.

Parameters:
- WIDTH, 12, flit width; bits [11:8] carry the destination ID, which this block does not interpret.
- NPORT, 5, number of requesting inputs; index 0 processor, 1 east, 2 south, 3 west, 4 north.
- DEPTH, 2, output buffer entries; must be 2 or more.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- req  input  NPORT  req[i] = input i's outport bit for this output port.
- data_in  input  NPORT*WIDTH  flit of input i on bits [i*WIDTH +: WIDTH].
- grant  output  NPORT  one-hot grant to input i; combinational from registered state and req.
- data_out  output  WIDTH  head-of-buffer flit.
- wr_en  output  1  write strobe into the downstream FIFO.
- dst_full  input  1  downstream FIFO full.
- count  output  $clog2(DEPTH+1)  buffer occupancy, for debug.

Behaviour:
- Reset (rst=1 at a clk edge) sets:
  - ptr=0, count=0, read and write indices 0.
  - grant=0, wr_en=0.
  - data_out = stale buffer contents; don't-care while count=0.
- Reset has priority over every other event. Reset mid-transfer discards buffered flits with no partial write: wr_en is 0 in the cycle after reset.
- space = (count < DEPTH). A simultaneous drain does not free space in the same cycle; this keeps dst_full off the grant path.
- Arbitration:
  - If space and req != 0, grant is one-hot at the first i with req[i]=1, scanning ptr, ptr+1, … modulo NPORT (4 wraps to 0).
  - Otherwise grant=0.
- Transfer: a transfer occurs in any cycle with grant[i]=1.
  - At the clk edge, data_in slice i is written at the write index.
  - Write index advances modulo DEPTH.
  - ptr <= (i+1) mod NPORT.
- ptr is unchanged in cycles with no grant.
- The grant is valid only in the cycle req is seen. Inputs that keep req high without a grant stay pending with no penalty.
- Latency: flit granted in cycle N appears on data_out with wr_en=1 in cycle N+1 if the buffer was empty and dst_full=0.
- Drain:
  - wr_en = (count != 0) & !dst_full.
  - On wr_en the read index advances modulo DEPTH.
  - data_out always shows the head entry.
- Occupancy: push without pop gives count+1; pop without push gives count-1; push and pop together leave count unchanged. count never exceeds DEPTH and never underflows.
- Full buffer: grant=0 for all inputs until count < DEPTH.
- Fairness: with all inputs requesting continuously, grants rotate 0,1,2,3,4,0… Any continuously requesting input is granted within NPORT grants.
- Single flit per packet: there is no wormhole lock, and consecutive grants may go to different inputs.
- Combinational loop: none. grant depends only on req and registers; wr_en and data_out depend only on registers and dst_full.

Test Plan:
1. Reset, then req=5'b00100 with flit 12'hA5C on input 2 and dst_full=0 → grant=5'b00100 that cycle; next cycle data_out=12'hA5C and wr_en=1; ptr=3.
2. req=5'b11111 held for 10 cycles, dst_full=0, starting at ptr=0 → grant sequence 1,2,4,8,16,1,2,… with exactly one wr_en per cycle from cycle 2 onward.
3. dst_full=1 with req=5'b00011 → two grants (input 0, then input 1), then grant=0 with count=2 and wr_en=0. Release dst_full → wr_en outputs input 0's flit, then input 1's, in order.
4. ptr=4 with req=5'b10001 → grant=5'b10000 and ptr wraps to 0. The next cycle, with the same req, grant=5'b00001.
5. count=1, push and pop in the same cycle (req=5'b01000, dst_full=0) → count stays 1 and the flits leave in FIFO order.
6. rst asserted for 1 cycle with count=2 and grant pending → the following cycle has count=0, wr_en=0, grant per ptr=0 (req=5'b00110 gives grant=5'b00010).
